// File: rtl/fb_port_arbiter_pkg.sv
// Shared types for the framebuffer port arbiter: arbiter states, read-return tags
// and the helper that sizes the starvation counter.
package fb_arb_pkg;

  typedef enum logic {
    NORMAL,
    DEFER
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SCAN,
    CORE
  } tag_t;

  localparam int STARVE_LIMIT_DFLT = 8;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

  localparam int CNT_W = cnt_width(STARVE_LIMIT_DFLT);

endpackage

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: VGA scanout has priority, and the RISC-V core
// gets one forced grant after STARVE_LIMIT consecutive blocked cycles.
//
// state  | meaning
// NORMAL | skid empty; normal priority arbitration
// DEFER  | skid holds one scanout read displaced by a forced core grant
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_BITS    = 19,
  parameter int PIXEL_BITS   = 3,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scan_req,
  input  logic [ADDR_BITS-1:0]  scan_addr,
  output logic                  scan_rvalid,
  output logic [PIXEL_BITS-1:0] scan_rdata,
  output logic                  scan_overrun,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_BITS-1:0]  core_addr,
  input  logic [PIXEL_BITS-1:0] core_wdata,
  output logic                  core_ready,
  output logic                  core_rvalid,
  output logic [PIXEL_BITS-1:0] core_rdata,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic                  mem_we,
  output logic [PIXEL_BITS-1:0] mem_wdata,
  input  logic [PIXEL_BITS-1:0] mem_rdata
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t                state;
  tag_t                  rd_tag;
  logic [ADDR_BITS-1:0]  skid_addr;
  logic [CW-1:0]         starve_cnt;
  logic [PIXEL_BITS-1:0] scan_rdata_q;
  logic [PIXEL_BITS-1:0] core_rdata_q;

  logic serve_skid;
  logic serve_scan;
  logic grant_core;
  logic forced;

  // Nothing is granted while reset is held, so a held core request cannot write.
  always_comb begin
    serve_skid = 1'b0;
    serve_scan = 1'b0;
    grant_core = 1'b0;
    forced     = 1'b0;
    if (!reset) begin
      if (state == DEFER) begin
        serve_skid = 1'b1;
      end else if (core_req && (starve_cnt == LIMIT)) begin
        grant_core = 1'b1;
        forced     = 1'b1;
      end else if (scan_req) begin
        serve_scan = 1'b1;
      end else if (core_req) begin
        grant_core = 1'b1;
      end
    end
  end

  assign core_ready = grant_core;
  assign mem_we     = grant_core & core_we;
  assign mem_wdata  = core_wdata;
  assign mem_addr   = serve_skid ? skid_addr :
                      serve_scan ? scan_addr : core_addr;

  // Return data passes straight from the RAM in its valid cycle and is held afterwards;
  // a read in flight when reset arrives is dropped.
  assign scan_rvalid = (rd_tag == SCAN) && !reset;
  assign core_rvalid = (rd_tag == CORE) && !reset;
  assign scan_rdata  = scan_rvalid ? mem_rdata : scan_rdata_q;
  assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= NORMAL;
      rd_tag       <= NONE;
      skid_addr    <= '0;
      starve_cnt   <= '0;
      scan_overrun <= 1'b0;
      scan_rdata_q <= '0;
      core_rdata_q <= '0;
    end else begin
      if (scan_rvalid) scan_rdata_q <= mem_rdata;
      if (core_rvalid) core_rdata_q <= mem_rdata;

      if (serve_skid || serve_scan)     rd_tag <= SCAN;
      else if (grant_core && !core_we)  rd_tag <= CORE;
      else                              rd_tag <= NONE;

      // Counts every cycle a pending core request is refused, including the DEFER cycle.
      if (!core_req || grant_core)      starve_cnt <= '0;
      else if (starve_cnt != LIMIT)     starve_cnt <= starve_cnt + CW'(1);

      if (serve_skid) begin
        state <= NORMAL;
        if (scan_req) scan_overrun <= 1'b1;
      end else if (forced && scan_req) begin
        skid_addr <= scan_addr;
        state     <= DEFER;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural arbitration and RAM model.
module tb_fb_port_arbiter;

  localparam int AB  = 19;
  localparam int PB  = 3;
  localparam int LIM = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          scan_req = 1'b0;
  logic [AB-1:0] scan_addr = '0;
  logic          scan_rvalid;
  logic [PB-1:0] scan_rdata;
  logic          scan_overrun;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AB-1:0] core_addr = '0;
  logic [PB-1:0] core_wdata = '0;
  logic          core_ready;
  logic          core_rvalid;
  logic [PB-1:0] core_rdata;
  logic [AB-1:0] mem_addr;
  logic          mem_we;
  logic [PB-1:0] mem_wdata;
  logic [PB-1:0] mem_rdata = '0;

  fb_port_arbiter #(.ADDR_BITS(AB), .PIXEL_BITS(PB), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_rvalid(scan_rvalid),
    .scan_rdata(scan_rdata), .scan_overrun(scan_overrun),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ready(core_ready), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Physical RAM seen by the DUT: preloaded with data = addr[2:0].
  logic [PB-1:0] ram [int];
  always @(posedge clock) begin
    mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : mem_addr[2:0];
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
  end

  // Reference model: shadow memory, pending return, deferred slot, blocked-cycle count.
  logic [PB-1:0] ref_mem [int];
  int            m_pend = 0;        // 0 none, 1 scanout read, 2 core read
  logic [PB-1:0] m_pend_data = '0;
  logic [PB-1:0] m_scan_hold = '0;
  logic [PB-1:0] m_core_hold = '0;
  bit            m_defer = 1'b0;
  bit            m_overrun = 1'b0;
  logic [AB-1:0] m_skid = '0;
  int            m_blocked = 0;
  int            ncyc = 0;
  int            lat_q[$];

  function automatic logic [PB-1:0] ref_rd(input logic [AB-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : a[2:0];
  endfunction

  always @(negedge clock) begin
    bit            e_srv, e_crv, e_ready;
    int            kind;
    int            t0;
    logic [AB-1:0] a;
    ncyc++;
    e_srv = !reset && (m_pend == 1);
    e_crv = !reset && (m_pend == 2);
    chk("scan_rvalid", scan_rvalid, e_srv);
    chk("scan_rdata", scan_rdata, e_srv ? m_pend_data : m_scan_hold);
    chk("core_rvalid", core_rvalid, e_crv);
    chk("core_rdata", core_rdata, e_crv ? m_pend_data : m_core_hold);
    chk("scan_overrun", scan_overrun, m_overrun);
    if (scan_rvalid === 1'b1) begin
      if (lat_q.size() == 0) chk("scan_unexpected_rvalid", 1, 0);
      else begin
        t0 = lat_q.pop_front();
        chk("scan_latency_le2", (ncyc - t0) <= 2, 1);
      end
    end
    if (reset) begin
      chk("reset_core_ready", core_ready, 0);
      chk("reset_mem_we", mem_we, 0);
      m_pend = 0; m_scan_hold = '0; m_core_hold = '0;
      m_defer = 1'b0; m_overrun = 1'b0; m_blocked = 0;
      lat_q.delete();
    end else begin
      kind = 0;
      if (m_defer)                             kind = 1;
      else if (core_req && m_blocked >= LIM)   kind = 2;
      else if (scan_req)                       kind = 3;
      else if (core_req)                       kind = 4;
      e_ready = (kind == 2) || (kind == 4);
      chk("core_ready", core_ready, e_ready);
      chk("mem_we", mem_we, e_ready && core_we);
      a = (kind == 1) ? m_skid : (kind == 3) ? scan_addr : core_addr;
      if (kind != 0) chk("mem_addr", mem_addr, a);
      if (e_srv) m_scan_hold = m_pend_data;
      if (e_crv) m_core_hold = m_pend_data;
      m_pend = 0;
      if (kind == 1 || kind == 3) begin
        m_pend = 1; m_pend_data = ref_rd(a);
      end else if (e_ready) begin
        if (core_we) ref_mem[int'(core_addr)] = core_wdata;
        else begin m_pend = 2; m_pend_data = ref_rd(core_addr); end
      end
      if (kind == 3) lat_q.push_back(ncyc);
      if (kind == 1 && scan_req) m_overrun = 1'b1;
      m_defer = (kind == 2) && scan_req;
      if (m_defer) begin m_skid = scan_addr; lat_q.push_back(ncyc); end
      m_blocked = (core_req && !e_ready) ? ((m_blocked + 1 > LIM) ? LIM : m_blocked + 1) : 0;
    end
  end

  task automatic step(input logic sr, input logic [AB-1:0] sa, input logic cr, input logic cw,
                      input logic [AB-1:0] ca, input logic [PB-1:0] cd);
    @(posedge clock); #1;
    scan_req = sr; scan_addr = sa; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
  endtask

  initial begin
    int first;
    int last_scan;
    bit pend, g;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // T1: scanout only, every second cycle
    for (int i = 0; i < 16; i++) begin
      step(1'b1, AB'(i), 1'b0, 1'b0, '0, '0);
      @(negedge clock); chk("t1_core_ready", core_ready, 0);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clock);
      chk("t1_scan_rvalid", scan_rvalid, 1);
      chk("t1_scan_rdata", scan_rdata, i[2:0]);
    end

    // T2: core write then read-back
    step(1'b0, '0, 1'b1, 1'b1, AB'('h100), 3'd5);
    @(negedge clock); chk("t2_wr_ready", core_ready, 1); chk("t2_wr_we", mem_we, 1);
    step(1'b0, '0, 1'b1, 1'b0, AB'('h100), 3'd0);
    @(negedge clock); chk("t2_rd_ready", core_ready, 1); chk("t2_rd_we", mem_we, 0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock); chk("t2_core_rvalid", core_rvalid, 1); chk("t2_core_rdata", core_rdata, 5);

    // T3: rate-legal scanout with core request held continuously
    first = -1;
    for (int k = 0; k < 20; k++) begin
      step((k % 2) == 0, AB'('h40 + k), 1'b1, 1'b0, AB'('h80), '0);
      @(negedge clock);
      if (core_ready && first < 0) first = k;
    end
    chk("t3_core_wait_le9", (first >= 0) && (first + 1 <= 9), 1);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // T4: back-to-back scanout starves the core, forced grant, overrun in the DEFER cycle
    for (int k = 0; k < 9; k++) begin
      step(1'b1, AB'('h13 + k), 1'b1, 1'b0, AB'('h205), '0);
      @(negedge clock); chk("t4_core_ready", core_ready, k == 8);
    end
    step(1'b1, AB'('h30), 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    chk("t4_skid_addr", mem_addr, 'h1b);
    chk("t4_core_rvalid", core_rvalid, 1); chk("t4_core_rdata", core_rdata, 5);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    chk("t4_skid_rvalid", scan_rvalid, 1); chk("t4_skid_rdata", scan_rdata, 3);
    chk("t4_overrun", scan_overrun, 1);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    chk("t4_dropped_no_rvalid", scan_rvalid, 0); chk("t4_overrun_sticky", scan_overrun, 1);

    // T5: reset right after a core read grant
    step(1'b0, '0, 1'b1, 1'b0, AB'('h300), '0);
    @(negedge clock); chk("t5_ready", core_ready, 1);
    @(posedge clock); #1 reset = 1'b1; core_req = 1'b0;
    @(negedge clock); chk("t5_no_rvalid", core_rvalid, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t5_scan_rvalid", scan_rvalid, 0); chk("t5_scan_rdata", scan_rdata, 0);
    chk("t5_core_rvalid", core_rvalid, 0); chk("t5_core_rdata", core_rdata, 0);
    chk("t5_overrun", scan_overrun, 0);

    // T6: random rate-legal scanout plus random core traffic
    last_scan = -10;
    pend = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock); g = core_ready;
      @(posedge clock); #1;
      if (pend && g) pend = 1'b0;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        core_we = 1'($urandom_range(0, 1));
        core_addr = AB'($urandom_range(0, 63));
        core_wdata = PB'($urandom_range(0, 7));
      end
      core_req = pend;
      if ((c - last_scan) >= 2 && $urandom_range(0, 1) == 1) begin
        scan_req = 1'b1; scan_addr = AB'($urandom_range(0, 63)); last_scan = c;
      end else scan_req = 1'b0;
    end
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clock); chk("t6_overrun", scan_overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
